// File: rtl/i2s_tx_pkg.sv
// rtl/i2s_tx_pkg.sv - shared constants and types for the I2S slave transmitter
// Contents:
//   SYNC_STAGES       - flops per clock-domain-crossing synchronizer on sck/ws
//   SCK_RATIO_MIN     - minimum clk_i cycles per SCK period
//   SAMPLE_WIDTH_DFLT - default bits per channel sample
//   stereo_pair_t     - {left, right} sample pair at the default width
//   tx_state_e        - transmitter channel-pairing state
package i2s_tx_pkg;

    localparam int SYNC_STAGES       = 2;
    localparam int SCK_RATIO_MIN     = 8;
    localparam int SAMPLE_WIDTH_DFLT = 24;

    typedef struct packed {
        logic [SAMPLE_WIDTH_DFLT-1:0] left;
        logic [SAMPLE_WIDTH_DFLT-1:0] right;
    } stereo_pair_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_LEFT,
        TX_SHIFT
    } tx_state_e;

endpackage

// File: rtl/i2s_tx_fifo.sv
// rtl/i2s_tx_fifo.sv - synchronous FIFO holding stereo sample pairs
// Ports:
//   clk_i, rst_i - clock, asynchronous active-high reset
//   push, wr_data - write request and data (ignored when full)
//   pop, rd_data  - read request (ignored when empty) and head-of-queue data
//   full, empty   - status derived from the registered count
//   count         - number of stored entries
module i2s_tx_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_slv_tx.sv
// rtl/i2s_slv_tx.sv - I2S slave transmitter (Philips format, MSB first)
// Ports:
//   clk_i, rst_i             - system clock (>= 8x SCK), async active-high reset
//   en_i                     - transmitter enable
//   wr_valid_i, wr_data_i    - push of a {left, right} pair
//   wr_ready_o, fifo_cnt_o   - FIFO not full, stored pair count
//   sck_i, ws_i              - bit clock and word select from the bus master
//   sd_o                     - serial data, changes after SCK falling edges
//   underflow_o              - one-cycle pulse when a left slot finds the FIFO empty
module i2s_slv_tx
    import i2s_tx_pkg::*;
#(
    parameter int SLOT_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 24,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic                          wr_valid_i,
    input  logic [2*SAMPLE_WIDTH-1:0]     wr_data_i,
    output logic                          wr_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
    input  logic                          sck_i,
    input  logic                          ws_i,
    output logic                          sd_o,
    output logic                          underflow_o
);

    localparam int CNT_W = $clog2(SLOT_WIDTH + 1);

    logic [SYNC_STAGES-1:0]    sck_sync;
    logic [SYNC_STAGES-1:0]    ws_sync;
    logic                      sck_prev;
    logic                      sck_cur;
    logic                      sck_rise;
    logic                      sck_fall;
    logic                      ws_r;
    logic                      ws_last;
    logic                      load_fall;

    logic                      ready_en;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic [2*SAMPLE_WIDTH-1:0] fifo_rd_data;

    tx_state_e                 state;
    tx_state_e                 state_nxt;
    logic                      ld_left;
    logic                      ld_right;
    logic                      uf_nxt;

    logic [SLOT_WIDTH-1:0]     shift_q;
    logic [SLOT_WIDTH-1:0]     word_load;
    logic [SAMPLE_WIDTH-1:0]   hold_q;
    logic [CNT_W-1:0]          bit_cnt;

    // SCK and WS are sampled through equal-length synchronizers so they stay aligned.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_i};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws_i};
            sck_prev <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign sck_cur  = sck_sync[SYNC_STAGES-1];
    assign sck_rise = !sck_prev && sck_cur;
    assign sck_fall = sck_prev && !sck_cur;

    // ws_r is WS as seen by the receiver; ws_last is the channel currently on the wire.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ws_r    <= 1'b0;
            ws_last <= 1'b0;
        end else begin
            if (sck_rise) begin
                ws_r <= ws_sync[SYNC_STAGES-1];
            end
            if (sck_fall) begin
                ws_last <= ws_r;
            end
        end
    end

    assign load_fall = sck_fall && (ws_r != ws_last);

    i2s_tx_fifo #(
        .WIDTH (2*SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (wr_valid_i && wr_ready_o),
        .wr_data (wr_data_i),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt_o)
    );

    // Holds wr_ready_o low while in reset, even though the empty FIFO is not full.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign wr_ready_o = ready_en && !fifo_full;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Right loads only count once a left load has happened, so a pair is never split.
    always_comb begin
        state_nxt = state;
        ld_left   = 1'b0;
        ld_right  = 1'b0;
        fifo_pop  = 1'b0;
        uf_nxt    = 1'b0;
        if (!en_i) begin
            state_nxt = TX_IDLE;
        end else begin
            case (state)
                TX_IDLE: begin
                    state_nxt = TX_WAIT_LEFT;
                end
                TX_WAIT_LEFT, TX_SHIFT: begin
                    if (load_fall && !ws_r) begin
                        ld_left   = 1'b1;
                        fifo_pop  = !fifo_empty;
                        uf_nxt    = fifo_empty;
                        state_nxt = TX_SHIFT;
                    end else if (load_fall && ws_r && state == TX_SHIFT) begin
                        ld_right = 1'b1;
                    end
                end
                default: begin
                    state_nxt = TX_IDLE;
                end
            endcase
        end
    end

    // Sample is left-aligned in the slot; the remaining low bits go out as zeros.
    always_comb begin
        word_load = '0;
        if (ld_left && !fifo_empty) begin
            word_load[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = fifo_rd_data[2*SAMPLE_WIDTH-1 -: SAMPLE_WIDTH];
        end else if (ld_right) begin
            word_load[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = hold_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q     <= '0;
            hold_q      <= '0;
            bit_cnt     <= '0;
            sd_o        <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            underflow_o <= uf_nxt;
            if (!en_i) begin
                shift_q <= '0;
                hold_q  <= '0;
                bit_cnt <= '0;
                sd_o    <= 1'b0;
            end else if (ld_left || ld_right) begin
                shift_q <= word_load;
                sd_o    <= word_load[SLOT_WIDTH-1];
                bit_cnt <= CNT_W'(1);
                if (ld_left) begin
                    hold_q <= fifo_empty ? '0 : fifo_rd_data[SAMPLE_WIDTH-1:0];
                end
            end else if (sck_fall && state == TX_SHIFT) begin
                // Past the end of the slot the line idles low until WS toggles.
                if (bit_cnt < CNT_W'(SLOT_WIDTH)) begin
                    shift_q <= {shift_q[SLOT_WIDTH-2:0], 1'b0};
                    sd_o    <= shift_q[SLOT_WIDTH-2];
                    bit_cnt <= bit_cnt + 1'b1;
                end else begin
                    sd_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_slv_tx.sv
// tb/tb_i2s_slv_tx.sv - directed self-checking bench for i2s_slv_tx
// Acts as I2S bus master (SCK/WS) and receiver sampling sd_o at SCK rising edges.
module tb_i2s_slv_tx;
    import i2s_tx_pkg::*;

    localparam int SCK_HALF = SCK_RATIO_MIN * 10 / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr_valid;
    logic [47:0] wr_data;
    logic        wr_ready;
    logic [3:0]  fifo_cnt;
    logic        sck;
    logic        ws;
    logic        sd;
    logic        underflow;

    int total = 0;
    int bad   = 0;
    int uf_seen = 0;

    i2s_slv_tx #(
        .SLOT_WIDTH   (32),
        .SAMPLE_WIDTH (24),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .wr_valid_i  (wr_valid),
        .wr_data_i   (wr_data),
        .wr_ready_o  (wr_ready),
        .fifo_cnt_o  (fifo_cnt),
        .sck_i       (sck),
        .ws_i        (ws),
        .sd_o        (sd),
        .underflow_o (underflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (underflow) begin
            uf_seen++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pair(input stereo_pair_t p);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = p;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // One SCK period: falling edge (WS updated with it), sample sd_o, rising edge.
    task automatic sck_cycle(input logic ws_val, output logic bit_o);
        sck = 1'b0;
        ws  = ws_val;
        #(SCK_HALF);
        bit_o = sd;
        sck = 1'b1;
        #(SCK_HALF);
    endtask

    // Leaves WS low after a right-channel fall so the next cycle loads left.
    task automatic prime();
        logic b;
        sck_cycle(1'b1, b);
        sck_cycle(1'b0, b);
    endtask

    // Bits sampled at rises 1..n are left, n+1..2n right; WS returns low at fall 2n.
    task automatic run_frame(input int n, input int en_at, output logic [31:0] l, output logic [31:0] r);
        logic b;
        l = '0;
        r = '0;
        for (int j = 1; j <= 2*n; j++) begin
            if (j == en_at) begin
                en = 1'b1;
            end
            sck_cycle((j >= n) && (j < 2*n), b);
            if (j <= n) begin
                l = {l[30:0], b};
            end else begin
                r = {r[30:0], b};
            end
        end
    endtask

    initial begin
        logic [31:0]  l;
        logic [31:0]  r;
        logic         b;
        logic [23:0]  lv;
        int           uf0;

        rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_data = '0; sck = 1'b1; ws = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sd", sd, 1'b0);
        chk("rst_uf", underflow, 1'b0);
        chk("rst_ready", wr_ready, 1'b0);
        chk("rst_cnt", fifo_cnt, 4'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", wr_ready, 1'b1);

        // Basic pair, 32-bit slots
        push_pair({24'hA5A5A5, 24'h5A5A5A});
        chk("cnt_one", fifo_cnt, 4'd1);
        en = 1'b1;
        @(negedge clk);
        prime();
        run_frame(32, 0, l, r);
        chk("basic_left", l, 32'hA5A5A500);
        chk("basic_right", r, 32'h5A5A5A00);
        chk("basic_cnt", fifo_cnt, 4'd0);
        chk("basic_no_uf", uf_seen, 0);

        // Empty FIFO: zeros and exactly one underflow pulse per frame
        uf0 = uf_seen;
        run_frame(32, 0, l, r);
        chk("uf_left_zero", l, 32'h0);
        chk("uf_right_zero", r, 32'h0);
        chk("uf_pulses", uf_seen - uf0, 1);

        // Fill to full, 9th push must be dropped
        for (int i = 0; i < 8; i++) begin
            lv = 24'(24'h111111 * (i + 1));
            push_pair({lv, ~lv});
        end
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = {24'hDEADBE, 24'hEFCAFE};
        repeat (3) @(negedge clk);
        chk("full_ready", wr_ready, 1'b0);
        chk("full_cnt", fifo_cnt, 4'd8);
        wr_valid = 1'b0;
        @(negedge clk);
        uf0 = uf_seen;
        for (int k = 0; k < 8; k++) begin
            run_frame(32, 0, l, r);
            lv = 24'(24'h111111 * (k + 1));
            chk("drain_left", l, {lv, 8'h00});
            chk("drain_right", r, {~lv, 8'h00});
            if (k == 0) begin
                chk("drain_ready", wr_ready, 1'b1);
                chk("drain_cnt7", fifo_cnt, 4'd7);
            end
        end
        chk("drain_empty", fifo_cnt, 4'd0);
        chk("drain_no_uf", uf_seen - uf0, 0);

        // Enable raised just before a right load: nothing goes out, nothing popped
        en = 1'b0;
        push_pair({24'hC3C3C3, 24'h3C3C3C});
        run_frame(32, 33, l, r);
        chk("late_en_left", l, 32'h0);
        chk("late_en_right", r, 32'h0);
        chk("late_en_cnt", fifo_cnt, 4'd1);
        run_frame(32, 0, l, r);
        chk("late_en_left2", l, 32'hC3C3C300);
        chk("late_en_right2", r, 32'h3C3C3C00);
        chk("late_en_cnt2", fifo_cnt, 4'd0);

        // 16-bit slots truncate, pairing stays aligned
        push_pair({24'h123456, 24'hABCDEF});
        push_pair({24'h654321, 24'hFEDCBA});
        run_frame(16, 0, l, r);
        chk("trunc_left0", l, 32'h1234);
        chk("trunc_right0", r, 32'hABCD);
        run_frame(16, 0, l, r);
        chk("trunc_left1", l, 32'h6543);
        chk("trunc_right1", r, 32'hFEDC);

        // Reset mid-slot
        push_pair({24'hFFFFFF, 24'hFFFFFF});
        for (int j = 0; j < 8; j++) begin
            sck_cycle(1'b0, b);
        end
        chk("mid_slot_sd", b, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_sd", sd, 1'b0);
        chk("mid_rst_cnt", fifo_cnt, 4'd0);
        #9;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_pair({24'h000001, 24'h800000});
        prime();
        run_frame(32, 0, l, r);
        chk("post_rst_left", l, 32'h00000100);
        chk("post_rst_right", r, 32'h80000000);
        chk("post_rst_msb", r[31], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_slv_tx.md
Name: i2s_slv_tx

Overview:
- Synthesizable I2S slave transmitter: the microphone-side source that drives the serial data line sampled by the apb4_i2s receiver.
- External SCK/WS come from the bus master. They are synchronized into clk_i and edge-detected.
- Stereo sample pairs are buffered in a small FIFO and shifted out MSB-first in Philips I2S format.
- Serves as an FPGA/emulation replacement for the behavioural mic model, and as a reusable TX path.

Parameters:
- SLOT_WIDTH, 32, SCK cycles per channel slot; bits beyond SAMPLE_WIDTH are sent as 0.
- SAMPLE_WIDTH, 24, bits per channel sample; must be ≤ SLOT_WIDTH.
- FIFO_DEPTH, 8, number of stereo pairs buffered; must be a power of 2, ≥ 2.

Ports:
- clk_i  in  1  system clock; must run ≥ 8× SCK frequency.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  transmitter enable.
- wr_valid_i  in  1  push request.
- wr_data_i  in  2*SAMPLE_WIDTH  {left, right} sample pair.
- wr_ready_o  out  1  FIFO not full.
- fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  stored pairs.
- sck_i  in  1  I2S bit clock from master (asynchronous).
- ws_i  in  1  word select from master (asynchronous); 0 = left, 1 = right.
- sd_o  out  1  serial data.
- underflow_o  out  1  one-cycle pulse on underflow.

Behaviour:
- Reset values (rst_i high, async): sd_o=0, underflow_o=0, wr_ready_o=0, fifo_cnt_o=0. The FIFO is emptied, shift register and bit counter are 0, and the synchronizer flops are 0.
- After reset release: wr_ready_o=1.
- Push: a push occurs when wr_valid_i && wr_ready_o at the clk_i rising edge. fifo_cnt_o increments one cycle later.
- Push when full: ignored, no state change.
- Simultaneous push and pop: count unchanged.
- Synchronizer: two-flop synchronizers on sck_i and ws_i, plus one history flop on SCK.
- Edge detection: sck_rise = !prev && cur; sck_fall = prev && !cur.
- ws_r: registered copy of synced WS, captured on sck_rise.
- ws_last: updated to ws_r on each sck_fall.
- Load condition: on sck_fall, if en_i && (ws_r != ws_last), load a word. This gives standard I2S timing: WS changes at fall n, is seen at rise n, and the MSB is driven from fall n+1.
- Load with ws_r=0 (left):
  - If the FIFO is non-empty: pop one pair, shift register ← {left, zeros}, hold register ← right.
  - If the FIFO is empty: shift register ← 0, hold ← 0, underflow_o pulses for 1 cycle.
- Load with ws_r=1 (right): shift register ← {hold, zeros}. No pop and no underflow check.
- sd_o drive:
  - On a load fall, sd_o ← shift[SLOT_WIDTH-1].
  - On every other sck_fall, shift left by 1 with zero fill, and sd_o ← the new MSB.
  - Bit counter saturates at SLOT_WIDTH; beyond that, sd_o=0.
- Slot longer than SLOT_WIDTH: zeros continue until the next WS transition.
- Slot shorter than SLOT_WIDTH: the word is truncated and the next word is loaded.
- Latency: sd_o updates 3 clk_i cycles after the SCK pad falling edge (2 sync + 1 output register).
- en_i low: sd_o forced 0, no pops, no underflow, bit counter cleared. ws_r and ws_last keep tracking.
- en_i rising mid-frame: sd_o stays 0 until the next left-channel load. A right load is ignored until the first left load after enable, so channel pairing is never split.
- Reset mid-frame: all state cleared immediately. Transmission resumes at the next left load after en_i.
- fifo_cnt_o and wr_ready_o are registered and consistent in the same cycle.

Decomposition:
- Package i2s_tx_pkg:
  - localparams for synchronizer depth (2) and SCK clock ratio minimum (8).
  - typedef stereo_pair_t {left, right} sized by SAMPLE_WIDTH.
  - enum tx_state_e {TX_IDLE, TX_WAIT_LEFT, TX_SHIFT}.
- FSM transitions:
  - TX_IDLE → TX_WAIT_LEFT when en_i.
  - TX_WAIT_LEFT → TX_SHIFT on a left load.
  - any state → TX_IDLE when !en_i.
- Sub-module i2s_tx_fifo: synchronous FIFO, FIFO_DEPTH entries of 2*SAMPLE_WIDTH bits. Ports: push, pop, full, empty, count.

Test Plan:
- Reset, push pair {24'hA5A5A5, 24'h5A5A5A}, enable, master SCK at clk/8 with 32-bit slots → receiver captures left=24'hA5A5A5 and right=24'h5A5A5A, each padded with 8 trailing zeros; fifo_cnt_o 1→0 at the left load.
- Push 8 pairs, then hold wr_valid_i high → wr_ready_o=0 and fifo_cnt_o=8; the 9th push is ignored; after one left load, wr_ready_o=1 and fifo_cnt_o=7.
- Empty FIFO with en_i=1 → sd_o stays 0 for the whole frame; underflow_o is exactly 1 pulse per left load and 0 on right loads.
- Assert en_i during a right slot → sd_o=0 until the next WS 1→0 transition; the first pair is emitted starting at left; no pop before that point.
- Master uses 16-bit slots → MSB-first truncation: left 24'h123456 appears on the wire as 16'h1234; the next pair still aligns correctly.
- Assert rst_i mid-slot, release, then push {24'h000001, 24'h800000} → sd_o=0 immediately on reset assertion; the next left slot carries 24'h000001 and the right slot has its MSB as the first bit.
